// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler for the 5-stage core
// Combinational stall/flush decode, a 3-state FSM for mul/div and held redirects.
module pipeline_hazard_ctrl #(
  parameter int addrWidth = 15,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [4:0]           exe_rd,
  input  logic                 exe_is_load,
  input  logic                 exe_mispredict,
  input  logic [addrWidth-1:0] exe_target,
  input  logic                 exe_muldiv,
  input  logic                 muldiv_done,
  input  logic                 im_wait,
  input  logic                 dm_wait,
  input  logic                 cnt_clr,
  output logic                 stall_pc,
  output logic                 stall_ifid,
  output logic                 stall_idexe,
  output logic                 stall_exemem,
  output logic                 flush_ifid,
  output logic                 flush_idexe,
  output logic                 flush_exemem,
  output logic                 redirect_valid,
  output logic [addrWidth-1:0] redirect_pc,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MULDIV     = 2'd1,
    REDIR_WAIT = 2'd2
  } state_t;

  state_t                 cur_state;
  state_t                 nxt_state;
  logic [addrWidth-1:0]   redir_q;
  logic                   take_redir;
  logic                   load_use;

  assign state = cur_state;

  assign load_use = exe_is_load && (exe_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == exe_rd)) ||
                     (id_use_rs2 && (id_rs2 == exe_rd)));

  always_comb begin
    stall_pc       = 1'b0;
    stall_ifid     = 1'b0;
    stall_idexe    = 1'b0;
    stall_exemem   = 1'b0;
    flush_ifid     = 1'b0;
    flush_idexe    = 1'b0;
    flush_exemem   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = redir_q;
    take_redir     = 1'b0;
    nxt_state      = cur_state;

    case (cur_state)
      REDIR_WAIT: begin
        redirect_valid = 1'b1;
        flush_ifid     = 1'b1;
        flush_idexe    = 1'b1;
        // With the PC frozen by a data wait the redirect cannot load yet.
        if (dm_wait) begin
          stall_pc     = 1'b1;
          stall_ifid   = 1'b1;
          stall_idexe  = 1'b1;
          stall_exemem = 1'b1;
        end else if (!im_wait) begin
          nxt_state = RUN;
        end
      end

      RUN, MULDIV: begin
        if (dm_wait) begin
          stall_pc     = 1'b1;
          stall_ifid   = 1'b1;
          stall_idexe  = 1'b1;
          stall_exemem = 1'b1;
        end else begin
          nxt_state = RUN;
          if (cur_state == MULDIV && !muldiv_done) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idexe  = 1'b1;
            flush_exemem = 1'b1;
            nxt_state    = MULDIV;
          end else if (exe_mispredict) begin
            redirect_valid = 1'b1;
            redirect_pc    = exe_target;
            flush_ifid     = 1'b1;
            flush_idexe    = 1'b1;
            take_redir     = 1'b1;
            nxt_state      = im_wait ? REDIR_WAIT : RUN;
          end else if (exe_muldiv && !muldiv_done) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idexe  = 1'b1;
            flush_exemem = 1'b1;
            nxt_state    = MULDIV;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            flush_idexe = 1'b1;
          end else if (im_wait) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
          end
        end
      end

      default: nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= RUN;
      redir_q   <= '0;
      stall_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      if (take_redir)
        redir_q <= exe_target;
      if (cnt_clr)
        stall_cnt <= '0;
      else if (stall_pc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
// Stimulus pushes hand-computed expectations; a monitor pops and compares at negedge.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, exe_rd;
  logic        id_use_rs1, id_use_rs2, exe_is_load, exe_mispredict;
  logic [14:0] exe_target;
  logic        exe_muldiv, muldiv_done, im_wait, dm_wait, cnt_clr;
  logic        stall_pc, stall_ifid, stall_idexe, stall_exemem;
  logic        flush_ifid, flush_idexe, flush_exemem, redirect_valid;
  logic [14:0] redirect_pc;
  logic [1:0]  state;
  logic [3:0]  stall_cnt;

  typedef struct packed {
    logic [3:0]  st;
    logic [2:0]  fl;
    logic        rv;
    logic [14:0] rpc;
    logic [1:0]  s;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic        chk = 1'b0;
  logic [3:0]  exp_cnt = 4'd0;
  int          total = 0;
  int          bad = 0;

  pipeline_hazard_ctrl #(.addrWidth(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .exe_rd(exe_rd), .exe_is_load(exe_is_load), .exe_mispredict(exe_mispredict),
    .exe_target(exe_target), .exe_muldiv(exe_muldiv), .muldiv_done(muldiv_done),
    .im_wait(im_wait), .dm_wait(dm_wait), .cnt_clr(cnt_clr),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idexe(stall_idexe),
    .stall_exemem(stall_exemem), .flush_ifid(flush_ifid), .flush_idexe(flush_idexe),
    .flush_exemem(flush_exemem), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk) begin
        if (sb_q.size() == 0) begin
          cmp("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          cmp("stalls", {28'd0, stall_pc, stall_ifid, stall_idexe, stall_exemem}, {28'd0, e.st});
          cmp("flushes", {29'd0, flush_ifid, flush_idexe, flush_exemem}, {29'd0, e.fl});
          cmp("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
          if (e.rv)
            cmp("redirect_pc", {17'd0, redirect_pc}, {17'd0, e.rpc});
          cmp("state", {30'd0, state}, {30'd0, e.s});
          cmp("stall_cnt", {28'd0, stall_cnt}, {28'd0, e.cnt});
        end
      end
    end
  end

  task automatic idle_in();
    id_rs1 = 0; id_rs2 = 0; exe_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    exe_is_load = 0; exe_mispredict = 0; exe_target = 0; exe_muldiv = 0;
    muldiv_done = 0; im_wait = 0; dm_wait = 0; cnt_clr = 0;
  endtask

  // One cycle: queue the expectation, let the monitor check it, then advance.
  task automatic step(input logic [3:0] st, input logic [2:0] fl, input logic rv,
                      input logic [14:0] rpc, input logic [1:0] s);
    exp_t e;
    e = '{st: st, fl: fl, rv: rv, rpc: rpc, s: s, cnt: exp_cnt};
    sb_q.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    if (rst || cnt_clr)             exp_cnt = 4'd0;
    else if (st[3] && exp_cnt != 4'hf) exp_cnt = exp_cnt + 4'd1;
    #1;
    chk = 1'b0;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    @(posedge clk); #1;
    step(4'b0000, 3'b000, 0, 0, 0);
    rst = 1'b0;
    step(4'b0000, 3'b000, 0, 0, 0);

    // load-use through rs2, then through rs1, then non-hazard variants
    exe_is_load = 1; exe_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
    step(4'b1100, 3'b010, 0, 0, 0);
    idle_in(); step(4'b0000, 3'b000, 0, 0, 0);
    exe_is_load = 1; exe_rd = 0; id_use_rs2 = 1; id_rs2 = 0;
    step(4'b0000, 3'b000, 0, 0, 0);
    idle_in(); exe_is_load = 1; exe_rd = 7; id_use_rs1 = 1; id_rs1 = 7;
    step(4'b1100, 3'b010, 0, 0, 0);
    id_use_rs1 = 0;
    step(4'b0000, 3'b000, 0, 0, 0);

    idle_in(); cnt_clr = 1; step(4'b0000, 3'b000, 0, 0, 0);

    // mul/div occupancy: 4 stall cycles, released on done
    idle_in(); exe_muldiv = 1;
    step(4'b1110, 3'b001, 0, 0, 0);
    step(4'b1110, 3'b001, 0, 0, 1);
    step(4'b1110, 3'b001, 0, 0, 1);
    step(4'b1110, 3'b001, 0, 0, 1);
    muldiv_done = 1;
    step(4'b0000, 3'b000, 0, 0, 1);
    idle_in(); step(4'b0000, 3'b000, 0, 0, 0);

    // mispredict held across fetch wait; second mispredict ignored
    exe_mispredict = 1; exe_target = 15'h1234; im_wait = 1;
    step(4'b0000, 3'b110, 1, 15'h1234, 0);
    exe_target = 15'h7777;
    step(4'b0000, 3'b110, 1, 15'h1234, 2);
    exe_mispredict = 0;
    step(4'b0000, 3'b110, 1, 15'h1234, 2);
    im_wait = 0;
    step(4'b0000, 3'b110, 1, 15'h1234, 2);
    idle_in(); step(4'b0000, 3'b000, 0, 0, 0);

    // zero-latency redirect
    exe_mispredict = 1; exe_target = 15'h0abc;
    step(4'b0000, 3'b110, 1, 15'h0abc, 0);
    idle_in(); step(4'b0000, 3'b000, 0, 0, 0);

    // dm_wait dominates mispredict and load-use; mispredict wins once released
    exe_mispredict = 1; exe_target = 15'h0555; exe_is_load = 1; exe_rd = 3;
    id_use_rs1 = 1; id_rs1 = 3; dm_wait = 1;
    step(4'b1111, 3'b000, 0, 0, 0);
    dm_wait = 0;
    step(4'b0000, 3'b110, 1, 15'h0555, 0);
    idle_in(); step(4'b0000, 3'b000, 0, 0, 0);

    // dm_wait inside MULDIV
    exe_muldiv = 1;
    step(4'b1110, 3'b001, 0, 0, 0);
    dm_wait = 1;
    step(4'b1111, 3'b000, 0, 0, 1);
    dm_wait = 0; muldiv_done = 1;
    step(4'b0000, 3'b000, 0, 0, 1);
    idle_in(); step(4'b0000, 3'b000, 0, 0, 0);

    // counter saturation and clear-over-increment
    cnt_clr = 1; step(4'b0000, 3'b000, 0, 0, 0);
    cnt_clr = 0; im_wait = 1;
    for (int i = 0; i < 18; i++) step(4'b1000, 3'b100, 0, 0, 0);
    cnt_clr = 1;
    step(4'b1000, 3'b100, 0, 0, 0);
    idle_in(); step(4'b0000, 3'b000, 0, 0, 0);

    // asynchronous reset mid-MULDIV
    exe_muldiv = 1;
    step(4'b1110, 3'b001, 0, 0, 0);
    step(4'b1110, 3'b001, 0, 0, 1);
    idle_in(); rst = 1'b1; exp_cnt = 4'd0;
    step(4'b0000, 3'b000, 0, 0, 0);
    rst = 1'b0;
    step(4'b0000, 3'b000, 0, 0, 0);

    @(negedge clk);
    cmp("scoreboard_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
